// File: rtl/add16_sched.sv
// add16_sched: round-robin sequencer that lets two add/sub clients share one
// 16-bit carry-lookahead adder slice; 32-bit jobs take two rippled passes.
module add16_sched (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [1:0]  i_req_valid,
  output logic [1:0]  o_req_ready,
  input  logic [1:0]  i_req_op0,
  input  logic [1:0]  i_req_op1,
  input  logic [31:0] i_req_a0,
  input  logic [31:0] i_req_b0,
  input  logic [31:0] i_req_a1,
  input  logic [31:0] i_req_b1,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic        o_rsp_id,
  output logic [31:0] o_rsp_sum,
  output logic        o_rsp_cout,
  output logic        o_rsp_ovf,
  output logic        o_busy,
  output logic [15:0] o_add_a,
  output logic [15:0] o_add_b,
  output logic        o_add_cin,
  input  logic [15:0] i_add_f,
  input  logic        i_add_px,
  input  logic        i_add_gx,
  input  logic        i_add_c14
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    RSP  = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_last;
  logic        r_id;
  logic [1:0]  r_op;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [15:0] r_sum_lo;
  logic [15:0] r_sum_hi;
  logic        r_carry;
  logic        r_ovf;
  logic        r_rsp_valid;
  logic        r_busy;

  logic [1:0]  w_grant;
  logic [1:0]  w_req_ready;
  logic        w_accept;
  logic        w_gnt_id;
  logic [1:0]  w_op_in;
  logic [31:0] w_a_in;
  logic [31:0] w_b_in;
  logic        w_sub;
  logic [31:0] w_b_eff;
  logic [15:0] w_add_a;
  logic [15:0] w_add_b;
  logic        w_add_cin;
  logic        w_carry;
  logic        w_ovf;

  // On contention the requester that was not served last time wins.
  always_comb begin
    w_grant = 2'b00;
    case (i_req_valid)
      2'b01:   w_grant = 2'b01;
      2'b10:   w_grant = 2'b10;
      2'b11:   w_grant = r_last ? 2'b01 : 2'b10;
      default: w_grant = 2'b00;
    endcase
  end

  assign w_req_ready = (i_rst_n && (r_state == IDLE)) ? w_grant : 2'b00;
  assign w_accept    = |w_req_ready;
  assign w_gnt_id    = w_req_ready[1];
  assign w_op_in     = w_gnt_id ? i_req_op1 : i_req_op0;
  assign w_a_in      = w_gnt_id ? i_req_a1  : i_req_a0;
  assign w_b_in      = w_gnt_id ? i_req_b1  : i_req_b0;

  // Subtract runs as a + ~b + 1; the +1 enters as the first-pass carry-in.
  assign w_sub   = r_op[0];
  assign w_b_eff = w_sub ? ~r_b : r_b;

  // Adder pins: low slice in LO, high slice with the rippled carry in HI.
  always_comb begin
    w_add_a   = 16'h0000;
    w_add_b   = 16'h0000;
    w_add_cin = 1'b0;
    case (r_state)
      LO: begin
        w_add_a   = r_a[15:0];
        w_add_b   = w_b_eff[15:0];
        w_add_cin = w_sub;
      end
      HI: begin
        w_add_a   = r_a[31:16];
        w_add_b   = w_b_eff[31:16];
        w_add_cin = r_carry;
      end
      default: begin
        w_add_a   = 16'h0000;
        w_add_b   = 16'h0000;
        w_add_cin = 1'b0;
      end
    endcase
  end

  assign w_carry = i_add_gx | (i_add_px & w_add_cin);
  assign w_ovf   = w_carry ^ i_add_c14;

  // Next-state sequencing.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) w_state_nxt = LO;
        else          w_state_nxt = IDLE;
      end
      LO:  w_state_nxt = r_op[1] ? HI : RSP;
      HI:  w_state_nxt = RSP;
      RSP: begin
        if (i_rsp_ready) w_state_nxt = IDLE;
        else             w_state_nxt = RSP;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  // Job capture at accept and per-pass result capture.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_last   <= 1'b1;
      r_id     <= 1'b0;
      r_op     <= 2'b00;
      r_a      <= 32'h0000_0000;
      r_b      <= 32'h0000_0000;
      r_sum_lo <= 16'h0000;
      r_sum_hi <= 16'h0000;
      r_carry  <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_last   <= w_gnt_id;
        r_id     <= w_gnt_id;
        r_op     <= w_op_in;
        r_a      <= w_a_in;
        r_b      <= w_b_in;
        r_sum_hi <= 16'h0000;
      end
      if (r_state == LO) begin
        r_sum_lo <= i_add_f;
        r_carry  <= w_carry;
        r_ovf    <= w_ovf;
      end
      if (r_state == HI) begin
        r_sum_hi <= i_add_f;
        r_carry  <= w_carry;
        r_ovf    <= w_ovf;
      end
    end
  end

  // Status flags registered from the upcoming state.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rsp_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_rsp_valid <= (w_state_nxt == RSP);
      r_busy      <= (w_state_nxt != IDLE);
    end
  end

  assign o_req_ready = w_req_ready;
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_id    = r_id;
  assign o_rsp_sum   = {r_sum_hi, r_sum_lo};
  assign o_rsp_cout  = r_carry;
  assign o_rsp_ovf   = r_ovf;
  assign o_busy      = r_busy;
  assign o_add_a     = w_add_a;
  assign o_add_b     = w_add_b;
  assign o_add_cin   = w_add_cin;

endmodule

// File: tb/tb_add16_sched.sv
// Randomized bench for add16_sched: a transaction-level model with an
// arithmetic adder stand-in, plus directed cases with literal expectations.
module tb_add16_sched;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [1:0]  req_op0, req_op1;
  logic [31:0] req_a0, req_b0, req_a1, req_b1;
  logic        rsp_valid, rsp_ready, rsp_id;
  logic [31:0] rsp_sum;
  logic        rsp_cout, rsp_ovf, busy;
  logic [15:0] add_a, add_b, add_f;
  logic        add_cin, add_px, add_gx, add_c14;
  logic [16:0] w_s16;
  logic [15:0] w_s15;

  int n_checks = 0;
  int n_errs   = 0;
  int n_rsp    = 0;

  add16_sched dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_op0(req_op0), .i_req_op1(req_op1),
    .i_req_a0(req_a0), .i_req_b0(req_b0), .i_req_a1(req_a1), .i_req_b1(req_b1),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_id(rsp_id),
    .o_rsp_sum(rsp_sum), .o_rsp_cout(rsp_cout), .o_rsp_ovf(rsp_ovf), .o_busy(busy),
    .o_add_a(add_a), .o_add_b(add_b), .o_add_cin(add_cin),
    .i_add_f(add_f), .i_add_px(add_px), .i_add_gx(add_gx), .i_add_c14(add_c14)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural stand-in for the 16-bit CLA slice.
  assign w_s16   = {1'b0, add_a} + {1'b0, add_b};
  assign w_s15   = {1'b0, add_a[14:0]} + {1'b0, add_b[14:0]} + {15'd0, add_cin};
  assign add_f   = add_a + add_b + {15'd0, add_cin};
  assign add_gx  = w_s16[16];
  assign add_px  = &(add_a ^ add_b);
  assign add_c14 = w_s15[15];

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Returns {ovf, cout, sum} for op applied to a, b from the arithmetic definition.
  function automatic logic [33:0] model_calc(input logic [1:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    logic [31:0] am, bm, sum;
    logic [32:0] t;
    logic        cout, ovf, sa, sb, sr;
    am = op[1] ? a : {16'd0, a[15:0]};
    bm = op[1] ? b : {16'd0, b[15:0]};
    t  = {1'b0, am} + {1'b0, bm};
    if (op[0]) begin
      sum  = am - bm;
      cout = (am >= bm);
    end else begin
      sum  = t[31:0];
      cout = op[1] ? t[32] : t[16];
    end
    if (!op[1]) sum = {16'd0, sum[15:0]};
    sa  = op[1] ? am[31] : am[15];
    sb  = op[1] ? bm[31] : bm[15];
    sr  = op[1] ? sum[31] : sum[15];
    ovf = op[0] ? ((sa != sb) && (sr != sa)) : ((sa == sb) && (sr != sa));
    return {ovf, cout, sum};
  endfunction

  // Transaction model state.
  bit          m_busy = 1'b0;
  bit          m_last = 1'b1;
  bit          m_id   = 1'b0;
  int          m_cyc  = 0;
  int          m_npass = 1;
  logic [1:0]  m_op   = 2'b00;
  logic [31:0] m_a    = 32'd0;
  logic [31:0] m_b    = 32'd0;
  logic [33:0] m_exp  = 34'd0;

  // Compare DUT against the model every cycle, then advance it over the next edge.
  always @(negedge clk) begin
    logic [1:0]  exp_rdy;
    logic [15:0] ea, eb;
    logic        ec, resp;
    logic [31:0] bx;
    logic [16:0] lo;
    if (!rst_n) begin
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp_id", 32'(rsp_id), 32'd0);
      chk("rst_rsp_sum", rsp_sum, 32'd0);
      chk("rst_rsp_cout", 32'(rsp_cout), 32'd0);
      chk("rst_rsp_ovf", 32'(rsp_ovf), 32'd0);
      chk("rst_add", {add_a, add_b}, 32'd0);
      chk("rst_add_cin", 32'(add_cin), 32'd0);
      m_busy = 1'b0;
      m_last = 1'b1;
    end else begin
      resp = m_busy && (m_cyc > m_npass);
      if (m_busy)                  exp_rdy = 2'b00;
      else if (req_valid == 2'b11) exp_rdy = m_last ? 2'b01 : 2'b10;
      else                         exp_rdy = req_valid;
      chk("req_ready", 32'(req_ready), 32'(exp_rdy));
      chk("busy", 32'(busy), 32'(m_busy));
      chk("rsp_valid", 32'(rsp_valid), 32'(resp));
      if (resp) begin
        chk("rsp_sum", rsp_sum, m_exp[31:0]);
        chk("rsp_cout", 32'(rsp_cout), 32'(m_exp[32]));
        chk("rsp_ovf", 32'(rsp_ovf), 32'(m_exp[33]));
        chk("rsp_id", 32'(rsp_id), 32'(m_id));
      end
      bx = m_op[0] ? ~m_b : m_b;
      lo = {1'b0, m_a[15:0]} + {1'b0, m_b[15:0]};
      ea = 16'd0; eb = 16'd0; ec = 1'b0;
      if (m_busy && m_cyc == 1) begin
        ea = m_a[15:0]; eb = bx[15:0]; ec = m_op[0];
      end else if (m_busy && m_cyc == 2 && m_npass == 2) begin
        ea = m_a[31:16]; eb = bx[31:16];
        ec = m_op[0] ? (m_a[15:0] >= m_b[15:0]) : lo[16];
      end
      chk("add_a", 32'(add_a), 32'(ea));
      chk("add_b", 32'(add_b), 32'(eb));
      chk("add_cin", 32'(add_cin), 32'(ec));
      if (!m_busy) begin
        if (exp_rdy != 2'b00) begin
          m_id    = exp_rdy[1];
          m_op    = m_id ? req_op1 : req_op0;
          m_a     = m_id ? req_a1 : req_a0;
          m_b     = m_id ? req_b1 : req_b0;
          m_exp   = model_calc(m_op, m_a, m_b);
          m_npass = m_op[1] ? 2 : 1;
          m_cyc   = 1;
          m_busy  = 1'b1;
          m_last  = m_id;
        end
      end else if (!resp) begin
        m_cyc++;
      end else if (rsp_ready) begin
        m_busy = 1'b0;
        n_rsp++;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic set_req(input logic id, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b);
    if (id) begin req_op1 = op; req_a1 = a; req_b1 = b; end
    else    begin req_op0 = op; req_a0 = a; req_b0 = b; end
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (busy && k < 40);
    chk("idle_timeout", 32'(busy), 32'd0);
  endtask

  // Single request with literal expectations on result and latency.
  task automatic do_req(input logic id, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] es, input logic ec,
                        input logic eo, input int elat);
    int k;
    bit got;
    @(posedge clk); #1;
    set_req(id, op, a, b);
    req_valid = id ? 2'b10 : 2'b01;
    got = 1'b0;
    k = 0;
    while (!got && k < 20) begin
      @(negedge clk);
      k++;
      if (req_ready[id]) got = 1'b1;
    end
    chk("accept", 32'(got), 32'd1);
    @(posedge clk); #1;
    req_valid = 2'b00;
    got = 1'b0;
    k = 0;
    while (!got && k < 20) begin
      @(negedge clk);
      k++;
      if (rsp_valid) got = 1'b1;
    end
    chk("rsp_latency", 32'(k), 32'(elat));
    chk("lit_sum", rsp_sum, es);
    chk("lit_cout", 32'(rsp_cout), 32'(ec));
    chk("lit_ovf", 32'(rsp_ovf), 32'(eo));
    chk("lit_id", 32'(rsp_id), 32'(id));
  endtask

  function automatic logic [31:0] rand_opnd();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h0000_7FFF;
      5: return 32'h0000_8000;
      6: return 32'h0000_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int prev_g, ngr;
    bit prev_rdy;
    rst_n = 1'b1; req_valid = 2'b00; rsp_ready = 1'b1;
    req_op0 = 2'b00; req_op1 = 2'b00;
    req_a0 = 32'd0; req_b0 = 32'd0; req_a1 = 32'd0; req_b1 = 32'd0;
    #2 rst_n = 1'b0;

    chk("model_add16", 32'(model_calc(2'b00, 32'h0000_7FFF, 32'h1) >> 32), 32'd2);
    chk("model_add16_sum", model_calc(2'b00, 32'h0000_7FFF, 32'h1) & 34'hFFFF_FFFF, 32'h0000_8000);
    chk("model_sub16_sum", model_calc(2'b01, 32'h0, 32'h1) & 34'hFFFF_FFFF, 32'h0000_FFFF);
    chk("model_sub32", 32'(model_calc(2'b11, 32'h8000_0000, 32'h1) >> 32), 32'd3);

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    do_req(1'b0, 2'b00, 32'h0000_7FFF, 32'h0000_0001, 32'h0000_8000, 1'b0, 1'b1, 2);
    do_req(1'b1, 2'b01, 32'h0000_0000, 32'h0000_0001, 32'h0000_FFFF, 1'b0, 1'b0, 2);
    do_req(1'b0, 2'b10, 32'h0000_FFFF, 32'h0000_0001, 32'h0001_0000, 1'b0, 1'b0, 3);
    do_req(1'b1, 2'b11, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1, 1'b1, 3);
    wait_idle();

    // Contention: grants must alternate, ready pulses one cycle wide.
    @(posedge clk); #1;
    set_req(1'b0, 2'b10, 32'h1234_5678, 32'h0FED_CBA9);
    set_req(1'b1, 2'b11, 32'h0000_0005, 32'h0000_0009);
    req_valid = 2'b11;
    prev_g = -1; ngr = 0; prev_rdy = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (req_ready != 2'b00) begin
        chk("rdy_pulse", 32'(prev_rdy), 32'd0);
        if (prev_g >= 0) chk("alternate", 32'(req_ready[1]), (prev_g == 0) ? 32'd1 : 32'd0);
        prev_g = int'(req_ready[1]);
        ngr++;
      end
      prev_rdy = |req_ready;
    end
    chk("alt_grants", 32'(ngr >= 8), 32'd1);
    @(posedge clk); #1;
    req_valid = 2'b00;
    wait_idle();

    // Back-pressure: response held, no grants while stalled.
    rsp_ready = 1'b0;
    do_req(1'b0, 2'b00, 32'h0000_1234, 32'h0000_4321, 32'h0000_5555, 1'b0, 1'b0, 2);
    @(posedge clk); #1;
    req_valid = 2'b11;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("bp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_sum", rsp_sum, 32'h0000_5555);
      chk("bp_ready", 32'(req_ready), 32'd0);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_regrant", 32'(req_ready), 32'd2);
    @(posedge clk); #1;
    req_valid = 2'b00;
    wait_idle();

    // Reset during the HI pass drops the job and restores priority.
    @(posedge clk); #1;
    set_req(1'b0, 2'b10, 32'h0001_FFFF, 32'h0000_0001);
    req_valid = 2'b01;
    @(negedge clk);
    chk("rst_accept", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 2'b00;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    set_req(1'b1, 2'b00, 32'h0000_0003, 32'h0000_0004);
    req_valid = 2'b11;
    @(negedge clk);
    chk("rst_first_grant", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 2'b00;
    wait_idle();

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      req_valid = 2'($urandom_range(0, 3));
      req_op0 = 2'($urandom_range(0, 3));
      req_op1 = 2'($urandom_range(0, 3));
      req_a0 = rand_opnd(); req_b0 = rand_opnd();
      req_a1 = rand_opnd(); req_b1 = rand_opnd();
      rsp_ready = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk); #1;
    req_valid = 2'b00;
    rsp_ready = 1'b1;
    wait_idle();
    chk("rand_responses", 32'(n_rsp > 200), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
